// File: rtl/scan_pattern_applier.sv
// scan_pattern_applier: applies stored stimulus/expected pairs to a
// full-scan CUT, captures once, unloads, compares and keeps statistics.
//
// Ports:
//   clk, reset        clock (also clocks the CUT), async active-low reset
//   pat_valid/ready   handshake for one stimulus/expected pair
//   pat_stim/exp/last stimulus, expected response, final-pattern flag
//   clear             in DONE: return to IDLE and zero the statistics
//   scan_en/in/out    CUT scan enable, chain head data, chain tail data
//   busy, done        pattern in flight / set finished
//   any_fail          sticky mismatch flag
//   pass_cnt/fail_cnt saturating pattern counters
//   first_fail_idx    index of the first failing pattern

module scan_pattern_applier #(
  parameter int CHAIN_LEN = 34,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  input  logic [CHAIN_LEN-1:0] pat_stim,
  input  logic [CHAIN_LEN-1:0] pat_exp,
  input  logic                 pat_last,
  input  logic                 clear,
  output logic                 scan_en,
  output logic                 scan_in,
  input  logic                 scan_out,
  output logic                 busy,
  output logic                 done,
  output logic                 any_fail,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     fail_cnt,
  output logic [CNT_W-1:0]     first_fail_idx
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CAPTURE,
    UNLOAD,
    COMPARE,
    DONE
  } state_t;

  localparam int BW =
    (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

  localparam logic [BW-1:0] LAST_BIT =
    BW'(CHAIN_LEN - 1);

  localparam logic [CNT_W-1:0] CNT_MAX =
    {CNT_W{1'b1}};

  state_t state;
  state_t nextState;

  logic [BW-1:0]        bitCnt;
  logic [CHAIN_LEN-1:0] stimReg;
  logic [CHAIN_LEN-1:0] expReg;
  logic [CHAIN_LEN-1:0] respReg;
  logic                 lastReg;
  logic                 scanInReg;

  logic [CNT_W-1:0] passCnt;
  logic [CNT_W-1:0] failCnt;
  logic [CNT_W-1:0] firstFailIdx;
  logic [CNT_W-1:0] patIdx;
  logic             anyFail;

  logic accept;
  logic bitWrap;
  logic shifting;
  logic doCompare;
  logic clearHit;
  logic match;

  assign bitWrap   = (bitCnt == LAST_BIT);
  assign shifting  = (state == LOAD) ||
                     (state == UNLOAD);
  assign doCompare = (state == COMPARE);
  assign clearHit  = (state == DONE) && clear;
  assign match     = (respReg == expReg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    pat_ready = 1'b0;
    scan_en   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        pat_ready = 1'b1;
        if (pat_valid) begin
          accept    = 1'b1;
          nextState = LOAD;
        end
      end
      LOAD: begin
        scan_en = 1'b1;
        busy    = 1'b1;
        if (bitWrap) begin
          nextState = CAPTURE;
        end
      end
      CAPTURE: begin
        busy      = 1'b1;
        nextState = UNLOAD;
      end
      UNLOAD: begin
        scan_en = 1'b1;
        busy    = 1'b1;
        if (bitWrap) begin
          nextState = COMPARE;
        end
      end
      COMPARE: begin
        busy      = 1'b1;
        nextState = lastReg ? DONE : IDLE;
      end
      DONE: begin
        done = 1'b1;
        if (clear) begin
          nextState = IDLE;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bitCnt <= '0;
    end else if (accept) begin
      bitCnt <= '0;
    end else if (shifting) begin
      if (bitWrap) begin
        bitCnt <= '0;
      end else begin
        bitCnt <= bitCnt + BW'(1);
      end
    end
  end

  // stimReg runs one bit ahead of scan_in so
  // the next bit is always at position 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stimReg <= '0;
      expReg  <= '0;
      lastReg <= 1'b0;
    end else if (accept) begin
      stimReg <= pat_stim >> 1;
      expReg  <= pat_exp;
      lastReg <= pat_last;
    end else if (state == LOAD) begin
      stimReg <= stimReg >> 1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scanInReg <= 1'b0;
    end else if (accept) begin
      scanInReg <= pat_stim[0];
    end else if (state == LOAD && !bitWrap) begin
      scanInReg <= stimReg[0];
    end else begin
      scanInReg <= 1'b0;
    end
  end

  assign scan_in = scanInReg;

  // First unload edge sees chain position 0,
  // which ends up in respReg[0].
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      respReg <= '0;
    end else if (state == UNLOAD) begin
      respReg <= {scan_out,
                  respReg[CHAIN_LEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      passCnt <= '0;
    end else if (clearHit) begin
      passCnt <= '0;
    end else if (doCompare && match) begin
      if (passCnt != CNT_MAX) begin
        passCnt <= passCnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      failCnt <= '0;
    end else if (clearHit) begin
      failCnt <= '0;
    end else if (doCompare && !match) begin
      if (failCnt != CNT_MAX) begin
        failCnt <= failCnt + CNT_W'(1);
      end
    end
  end

  // anyFail doubles as the "already seen a
  // failure" marker, so a saturated failCnt
  // cannot re-arm the first-fail capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      anyFail      <= 1'b0;
      firstFailIdx <= '0;
    end else if (clearHit) begin
      anyFail      <= 1'b0;
      firstFailIdx <= '0;
    end else if (doCompare && !match) begin
      anyFail <= 1'b1;
      if (!anyFail) begin
        firstFailIdx <= patIdx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      patIdx <= '0;
    end else if (clearHit) begin
      patIdx <= '0;
    end else if (doCompare) begin
      if (patIdx != CNT_MAX) begin
        patIdx <= patIdx + CNT_W'(1);
      end
    end
  end

  assign any_fail       = anyFail;
  assign pass_cnt       = passCnt;
  assign fail_cnt       = failCnt;
  assign first_fail_idx = firstFailIdx;

endmodule

// File: tb/tb_scan_pattern_applier.sv
// tb_scan_pattern_applier: directed vectors against a bench CUT
// (shift register, capture = bitwise inverse), scoreboard on completion.

module tb_scan_pattern_applier;

  localparam int N = 34;
  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic         pat_valid;
  logic         pat_ready;
  logic [N-1:0] pat_stim;
  logic [N-1:0] pat_exp;
  logic         pat_last;
  logic         clear;
  logic         scan_en;
  logic         scan_in;
  logic         scan_out;
  logic         busy;
  logic         done;
  logic         any_fail;
  logic [W-1:0] pass_cnt;
  logic [W-1:0] fail_cnt;
  logic [W-1:0] first_fail_idx;

  scan_pattern_applier #(
    .CHAIN_LEN(N),
    .CNT_W(W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pat_valid(pat_valid),
    .pat_ready(pat_ready),
    .pat_stim(pat_stim),
    .pat_exp(pat_exp),
    .pat_last(pat_last),
    .clear(clear),
    .scan_en(scan_en),
    .scan_in(scan_in),
    .scan_out(scan_out),
    .busy(busy),
    .done(done),
    .any_fail(any_fail),
    .pass_cnt(pass_cnt),
    .fail_cnt(fail_cnt),
    .first_fail_idx(first_fail_idx)
  );

  logic [N-1:0] cut = '0;

  always @(posedge clk) begin
    if (scan_en) cut <= {scan_in, cut[N-1:1]};
    else         cut <= ~cut;
  end

  assign scan_out = cut[0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] passCnt;
    logic [W-1:0] failCnt;
    logic [W-1:0] ffi;
    logic         anyFail;
    logic         done;
  } exp_t;

  exp_t sbQ[$];
  exp_t mon;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [W-1:0] mPass = '0;
  logic [W-1:0] mFail = '0;
  logic [W-1:0] mFfi  = '0;
  logic [W-1:0] mIdx  = '0;
  logic         mAny  = 1'b0;

  logic prevBusy = 1'b0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] req);
    nCompared++;
    if (act !== req) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, req);
    end
  endtask

  task automatic modelReset();
    mPass = '0;
    mFail = '0;
    mFfi  = '0;
    mIdx  = '0;
    mAny  = 1'b0;
  endtask

  task automatic expectPat(input logic last,
                           input logic shouldPass);
    exp_t e;
    if (shouldPass) begin
      mPass++;
    end else begin
      mFail++;
      if (!mAny) mFfi = mIdx;
      mAny = 1'b1;
    end
    mIdx++;
    e.passCnt = mPass;
    e.failCnt = mFail;
    e.ffi     = mFfi;
    e.anyFail = mAny;
    e.done    = last;
    sbQ.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      prevBusy = 1'b0;
    end else begin
      if (prevBusy && !busy) begin
        if (sbQ.size() == 0) begin
          check("sb_unexpected_done", 1, 0);
        end else begin
          mon = sbQ.pop_front();
          check("sb_pass_cnt", pass_cnt, mon.passCnt);
          check("sb_fail_cnt", fail_cnt, mon.failCnt);
          check("sb_any_fail", any_fail, mon.anyFail);
          check("sb_first_fail", first_fail_idx,
                mon.ffi);
          check("sb_done", done, mon.done);
        end
      end
      prevBusy = busy;
    end
  end

  task automatic applyPat(input logic [N-1:0] stim,
                          input logic [N-1:0] expv,
                          input logic last,
                          input logic shouldPass,
                          output int gap);
    int n;
    n = 0;
    while (!pat_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    gap = -1;
    if (!pat_ready) begin
      check("ready_timeout", 0, 1);
      return;
    end
    pat_stim  = stim;
    pat_exp   = expv;
    pat_last  = last;
    pat_valid = 1'b1;
    expectPat(last, shouldPass);
    @(posedge clk);
    #1;
    pat_valid = 1'b0;
    pat_stim  = ~stim;
    pat_exp   = ~expv;
    pat_last  = ~last;
    gap = 0;
    while (gap < 300) begin
      @(negedge clk);
      if (pat_ready || done) break;
      gap++;
    end
  endtask

  task automatic doClear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    modelReset();
    check("clr_ready", pat_ready, 1);
    check("clr_done", done, 0);
    check("clr_pass", pass_cnt, 0);
    check("clr_fail", fail_cnt, 0);
    check("clr_any", any_fail, 0);
    check("clr_ffi", first_fail_idx, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: no finish, got t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] s;
    int gap;
    int errs;

    reset     = 1'b0;
    pat_valid = 1'b0;
    pat_stim  = '0;
    pat_exp   = '0;
    pat_last  = 1'b0;
    clear     = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_ready", pat_ready, 1);
    check("rst_scan_en", scan_en, 0);
    check("rst_scan_in", scan_in, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_any", any_fail, 0);
    check("rst_pass", pass_cnt, 0);
    check("rst_fail", fail_cnt, 0);
    check("rst_ffi", first_fail_idx, 0);
    reset = 1'b1;
    @(negedge clk);

    // single matching pattern, cycle by cycle
    s = 34'h0_0000_0001;
    pat_stim  = s;
    pat_exp   = 34'h3_FFFF_FFFE;
    pat_last  = 1'b1;
    pat_valid = 1'b1;
    expectPat(1'b1, 1'b1);
    @(posedge clk);
    #1;
    pat_valid = 1'b0;
    pat_stim  = '0;
    pat_exp   = '0;
    errs = 0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      if (scan_en !== 1'b1 || scan_in !== s[i]) errs++;
    end
    check("load_seq_errs", errs, 0);
    @(negedge clk);
    check("capture_scan_en", scan_en, 0);
    check("capture_busy", busy, 1);
    errs = 0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      if (scan_en !== 1'b1 || scan_in !== 1'b0) errs++;
    end
    check("unload_seq_errs", errs, 0);
    @(negedge clk);
    check("compare_scan_en", scan_en, 0);
    check("compare_done", done, 0);
    @(negedge clk);
    check("t1_done", done, 1);
    check("t1_ready", pat_ready, 0);
    check("t1_pass", pass_cnt, 1);

    doClear();

    // single mismatch
    applyPat(34'h2_AAAA_AAAA, 34'h2_AAAA_AAAA,
             1'b1, 1'b0, gap);
    check("t2_gap", gap, 70);
    check("t2_fail", fail_cnt, 1);

    doClear();

    // three patterns, middle one wrong
    applyPat(34'h0_1234_5678, 34'h3_EDCB_A987,
             1'b0, 1'b1, gap);
    check("t3_gap0", gap, 70);
    applyPat(34'h3_0000_FFFF, 34'h0_FFFF_0001,
             1'b0, 1'b0, gap);
    check("t3_gap1", gap, 70);
    applyPat(34'h1_8000_0001, 34'h2_7FFF_FFFE,
             1'b1, 1'b1, gap);
    check("t3_gap2", gap, 70);
    check("t3_ffi", first_fail_idx, 1);

    doClear();

    // reset in the middle of UNLOAD
    applyPat(34'h0_0000_00FF, 34'h3_FFFF_FF00,
             1'b0, 1'b1, gap);
    check("t4_pre_pass", pass_cnt, 1);
    pat_stim  = 34'h1_2345_6789;
    pat_exp   = 34'h0;
    pat_last  = 1'b0;
    pat_valid = 1'b1;
    @(posedge clk);
    #1;
    pat_valid = 1'b0;
    repeat (50) @(negedge clk);
    check("t4_in_unload", scan_en, 1);
    #2;
    reset = 1'b0;
    #1;
    check("t4_async_scan_en", scan_en, 0);
    check("t4_async_busy", busy, 0);
    check("t4_async_ready", pat_ready, 1);
    check("t4_async_pass", pass_cnt, 0);
    modelReset();
    sbQ.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    applyPat(34'h0, 34'h0, 1'b1, 1'b0, gap);
    check("t4_ffi_after_rst", first_fail_idx, 0);

    // pat_valid held in DONE, then clear
    s = 34'h3_FFFF_FFFF;
    pat_stim  = s;
    pat_exp   = 34'h0;
    pat_last  = 1'b1;
    pat_valid = 1'b1;
    repeat (5) @(negedge clk);
    check("t5_hold_ready", pat_ready, 0);
    check("t5_hold_done", done, 1);
    check("t5_hold_fail", fail_cnt, 1);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    modelReset();
    check("t5_clr_ready", pat_ready, 1);
    check("t5_clr_done", done, 0);
    check("t5_clr_fail", fail_cnt, 0);
    expectPat(1'b1, 1'b1);
    @(posedge clk);
    #1;
    pat_valid = 1'b0;
    @(negedge clk);
    check("t5_accept_busy", busy, 1);
    check("t5_accept_ready", pat_ready, 0);
    gap = 0;
    while (!done && gap < 300) begin
      @(negedge clk);
      gap++;
    end
    check("t5_done_reached", done, 1);
    @(negedge clk);
    check("sb_drained", sbQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCompared, nMismatched);
    $finish;
  end

endmodule
